// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller.
//   - state_e     : controller state encoding (IDLE / REDIRECT / FLUSH)
//   - ALIGN_MASK  : low PC bits that must be zero for a legal fetch target
//   - is_word_aligned() : alignment test on the two low target bits
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return ((addr_lsb & ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter used for the branch statistics.
// Ports:
//   clk  : core clock
//   rst  : asynchronous, active-high reset (clears the count)
//   inc  : add one this cycle unless already at all-ones
//   q    : current count (registered)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Count register: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else if (inc && (q_r != {W{1'b1}})) begin
            q_r <= q_r + W'(1'b1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: turns the EX-stage branch/jump decision into
// a PC redirect plus a fixed-length flush window for the IF/ID and ID/EX
// registers, squashing anything EX presents while that window is open.
// Prediction is static not-taken, so only taken control flow redirects.
// Ports:
//   clk, rst          : core clock, asynchronous active-high reset
//   ex_valid/branch/jump/cond/target : EX-stage instruction and decision
//   stall             : freezes the controller (state, window count, outputs)
//   pc_redirect       : PC mux selects redirect_pc (first window cycle)
//   redirect_pc       : registered redirect target
//   flush_if_id/id_ex : pipeline register zero strobes (whole window)
//   misalign_err      : one-cycle pulse for a taken, non word-aligned target
//   busy              : controller is in the redirect/flush window
//   br_count          : resolved conditional branches (saturating)
//   br_taken_count    : taken conditional branches (saturating)
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_cond,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             stall,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign_err,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] br_taken_count
);

    // Window counter only has to hold FLUSH_CYCLES-1.
    localparam int CW = (FLUSH_CYCLES > 1) ? ($clog2(FLUSH_CYCLES) + 1) : 1;
    localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);

    state_e          state_r;
    state_e          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic [XLEN-1:0] redirect_pc_r;
    logic [XLEN-1:0] redirect_pc_next_s;
    logic            misalign_r;
    logic            misalign_next_s;
    logic            pc_redirect_r;
    logic            window_r;
    logic            take_s;
    logic            accept_s;
    logic            br_inc_s;
    logic            taken_inc_s;

    // EX qualification: EX is only looked at in IDLE and when not stalled,
    // which is what squashes wrong-path instructions inside the window.
    always_comb begin
        take_s      = ex_valid & (ex_jump | (ex_branch & ex_cond));
        accept_s    = (state_r == ST_IDLE) & ~stall;
        br_inc_s    = accept_s & ex_valid & ex_branch;
        taken_inc_s = br_inc_s & ex_cond;
    end

    // Next-state, window count, target capture and misalignment detection.
    always_comb begin
        state_next_s       = state_r;
        cnt_next_s         = cnt_r;
        redirect_pc_next_s = redirect_pc_r;
        misalign_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && take_s) begin
                    if (is_word_aligned(ex_target[1:0])) begin
                        redirect_pc_next_s = ex_target;
                        state_next_s       = ST_REDIRECT;
                    end else begin
                        misalign_next_s    = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (stall) begin
                    state_next_s = ST_REDIRECT;
                end else if (FLUSH_CYCLES == 1) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FLUSH;
                    cnt_next_s   = FLUSH_RELOAD;
                end
            end
            ST_FLUSH: begin
                if (stall) begin
                    state_next_s = ST_FLUSH;
                end else if (cnt_r == CNT_ONE) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state register without any ex_* to output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            redirect_pc_r <= {XLEN{1'b0}};
            misalign_r    <= 1'b0;
            pc_redirect_r <= 1'b0;
            window_r      <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            redirect_pc_r <= redirect_pc_next_s;
            misalign_r    <= misalign_next_s;
            pc_redirect_r <= (state_next_s == ST_REDIRECT);
            window_r      <= (state_next_s != ST_IDLE);
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br_inc_s),
        .q   (br_count)
    );

    sat_counter #(.W(CNT_W)) u_br_taken_cnt (
        .clk (clk),
        .rst (rst),
        .inc (taken_inc_s),
        .q   (br_taken_count)
    );

    assign pc_redirect  = pc_redirect_r;
    assign redirect_pc  = redirect_pc_r;
    assign flush_if_id  = window_r;
    assign flush_id_ex  = window_r;
    assign busy         = window_r;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl (FLUSH_CYCLES=2, CNT_W=4 so
// saturation is reachable). Stimulus pushes the expected event records;
// the monitor pops one whenever the DUT opens a redirect window, pulses
// misalign_err, or a reset snapshot is requested.
module tb_branch_redirect_ctrl;

    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam int CW   = 4;

    localparam int K_REDIR = 0;
    localparam int K_MIS   = 1;
    localparam int K_SNAP  = 2;

    typedef struct {
        int          kind;
        logic [31:0] pc;
        int          red;
        int          fl;
        int          brc;
        int          brt;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ex_valid = 1'b0;
    logic            ex_branch = 1'b0;
    logic            ex_jump = 1'b0;
    logic            ex_cond = 1'b0;
    logic [XLEN-1:0] ex_target = 32'h0;
    logic            stall = 1'b0;
    logic            pc_redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            misalign_err;
    logic            busy;
    logic [CW-1:0]   br_count;
    logic [CW-1:0]   br_taken_count;

    rec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   snap_req = 0;
    int   snap_seen = 0;
    bit   stim_done = 1'b0;
    event snap_ev;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_cond        (ex_cond),
        .ex_target      (ex_target),
        .stall          (stall),
        .pc_redirect    (pc_redirect),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .misalign_err   (misalign_err),
        .busy           (busy),
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
    );

    task automatic push(input int kind, input logic [31:0] pc, input int red,
                        input int fl, input int brc, input int brt);
        rec_t r;
        r.kind = kind; r.pc = pc; r.red = red; r.fl = fl; r.brc = brc; r.brt = brt;
        exp_q.push_back(r);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_cond = 1'b0;
        ex_target = 32'h0;
    endtask

    // Present one EX instruction for exactly one clock edge.
    task automatic issue(input logic v, input logic b, input logic j,
                         input logic c, input logic [31:0] tgt);
        ex_valid = v; ex_branch = b; ex_jump = j; ex_cond = c; ex_target = tgt;
        step(1);
        clear_ex();
    endtask

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic take_rec(input int kind, output rec_t r, output bit ok);
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
            r.kind = kind; r.pc = 32'h0; r.red = 0; r.fl = 0; r.brc = 0; r.brt = 0;
            ok = 1'b0;
        end else begin
            r = exp_q.pop_front();
            chk("event_kind", kind, r.kind);
            ok = 1'b1;
        end
    endtask

    // Stimulus: directed vectors, expected records pushed before issue.
    initial begin : stim
        #3;
        push(K_SNAP, 32'h0, 0, 0, 0, 0);
        snap_req++;
        -> snap_ev;
        step(2);
        rst = 1'b0;
        step(1);

        // Taken BEQ to 0x40.
        push(K_REDIR, 32'h40, 1, 2, 1, 1);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        step(4);

        // Not-taken branch: counted, no event.
        issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
        step(2);

        // Jump: redirects, not counted.
        push(K_REDIR, 32'h100, 1, 2, 2, 1);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
        step(4);

        // Misaligned taken branch: pulse only, still counted.
        push(K_MIS, 32'h0, 0, 0, 3, 2);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h42);
        step(3);

        // Stall for 3 cycles during REDIRECT: 4 redirect, 5 flush cycles.
        push(K_REDIR, 32'h200, 4, 5, 4, 3);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        stall = 1'b1;
        step(3);
        stall = 1'b0;
        step(5);

        // Taken branch while stalled in IDLE: ignored entirely.
        stall = 1'b1;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_cond = 1'b1; ex_target = 32'h300;
        step(2);
        stall = 1'b0;
        clear_ex();
        step(1);

        // Wrong-path taken branch to 0x80 during REDIRECT and FLUSH: squashed.
        push(K_REDIR, 32'h60, 1, 2, 5, 4);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h60);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_cond = 1'b1; ex_target = 32'h80;
        step(2);
        clear_ex();
        step(3);

        // Back-to-back: jump in the first IDLE cycle after FLUSH.
        push(K_REDIR, 32'h10, 1, 2, 6, 5);
        push(K_REDIR, 32'h20, 1, 2, 6, 5);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h10);
        step(2);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h20);
        step(4);

        // Asynchronous reset in the FLUSH cycle, between clock edges.
        push(K_REDIR, 32'h44, 1, 2, 0, 0);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h44);
        step(1);
        #5;
        rst = 1'b1;
        #1;
        push(K_SNAP, 32'h0, 0, 0, 0, 0);
        snap_req++;
        -> snap_ev;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3);

        // Saturation: 17 taken (misaligned) branches back to back.
        for (int i = 1; i <= 17; i++) begin
            push(K_MIS, 32'h0, 0, 0, (i > 15) ? 15 : i, (i > 15) ? 15 : i);
            issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h3);
        end
        step(2);

        push(K_REDIR, 32'h400, 1, 2, 15, 15);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h400);
        step(5);
        stim_done = 1'b1;
    end

    // Monitor: pops and compares whenever the DUT presents an event.
    initial begin : monitor
        rec_t cur;
        rec_t r;
        bit   ok;
        bit   in_win;
        bit   pc_ok;
        int   red;
        int   fl;
        int   drain;
        in_win = 1'b0; pc_ok = 1'b1; red = 0; fl = 0; drain = 0;
        cur.kind = K_REDIR; cur.pc = 32'h0; cur.red = 0; cur.fl = 0; cur.brc = 0; cur.brt = 0;
        forever begin
            @(negedge clk or snap_ev);
            if (snap_seen != snap_req) begin
                snap_seen++;
                take_rec(K_SNAP, r, ok);
                if (ok) begin
                    chk("rst_pc_redirect", pc_redirect, 0);
                    chk("rst_flush_if_id", flush_if_id, 0);
                    chk("rst_flush_id_ex", flush_id_ex, 0);
                    chk("rst_misalign_err", misalign_err, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_redirect_pc", redirect_pc, r.pc);
                    chk("rst_br_count", br_count, r.brc);
                    chk("rst_br_taken_count", br_taken_count, r.brt);
                end
            end else begin
                if (busy && !in_win) begin
                    take_rec(K_REDIR, r, ok);
                    cur = r;
                    chk("redirect_target", redirect_pc, cur.pc);
                    chk("redirect_first_cycle", pc_redirect, 1);
                    in_win = 1'b1; red = 0; fl = 0; pc_ok = 1'b1;
                end
                if (in_win) begin
                    if (busy && ((red + fl) < 40)) begin
                        red += int'(pc_redirect);
                        fl  += int'(flush_if_id && flush_id_ex);
                        if (redirect_pc != cur.pc) pc_ok = 1'b0;
                    end else begin
                        chk("redirect_cycles", red, cur.red);
                        chk("flush_cycles", fl, cur.fl);
                        chk("redirect_pc_held", pc_ok, 1);
                        chk("br_count", br_count, cur.brc);
                        chk("br_taken_count", br_taken_count, cur.brt);
                        in_win = 1'b0;
                    end
                end
                if (misalign_err) begin
                    take_rec(K_MIS, r, ok);
                    if (ok) begin
                        chk("misalign_no_redirect", pc_redirect, 0);
                        chk("misalign_idle", busy, 0);
                        chk("misalign_br_count", br_count, r.brc);
                        chk("misalign_br_taken_count", br_taken_count, r.brt);
                    end
                end
                if (stim_done && !in_win) begin
                    if ((exp_q.size() == 0) || (drain >= 20)) begin
                        chk("events_outstanding", exp_q.size(), 0);
                        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                        $finish;
                    end
                    drain++;
                end
            end
        end
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-flow changes for the pipelined core.
- Takes the 1-bit branch decision produced in EX, plus jump/branch qualifiers and the computed target.
- Drives the PC-select redirect and the IF/ID and ID/EX flush strobes over a fixed flush window.
- Squashes wrong-path branches inside that window and keeps saturating branch statistics. Sits between the EX stage and the fetch/pipeline-register logic.

Parameters:
XLEN, 32, width of PC/target
FLUSH_CYCLES, 2, cycles flush strobes stay high after redirect (>=1)
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  core clock
rst  input  1  reset; asynchronous, active-high
ex_valid  input  1  EX holds a real (non-bubble) instruction
ex_branch  input  1  EX instruction is a conditional branch
ex_jump  input  1  EX instruction is JAL/JALR
ex_cond  input  1  branch-decision signal (1 = condition met)
ex_target  input  XLEN  computed branch/jump target
stall  input  1  pipeline stall (memory/hazard); freezes controller progress
pc_redirect  output  1  PC mux selects redirect_pc this cycle
redirect_pc  output  XLEN  registered redirect target
flush_if_id  output  1  zero IF/ID register
flush_id_ex  output  1  zero ID/EX register
misalign_err  output  1  one-cycle pulse: taken target not 4-byte aligned
busy  output  1  state != IDLE
br_count  output  CNT_W  resolved conditional branches
br_taken_count  output  CNT_W  taken conditional branches

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, all outputs 0, redirect_pc=0, counters=0. Reset mid-REDIRECT/FLUSH aborts immediately; no redirect issued after release.
- Static not-taken prediction. take = ex_valid & (ex_jump | (ex_branch & ex_cond)).
- States: IDLE, REDIRECT, FLUSH.
- IDLE:
  - If !stall & take & ex_target[1:0]==0: redirect_pc<=ex_target, next state REDIRECT.
  - If !stall & take & ex_target[1:0]!=0: misalign_err=1 next cycle for one cycle, stay IDLE, no redirect.
  - With stall=1: EX inputs are ignored.
- REDIRECT:
  - pc_redirect=1, flush_if_id=1, flush_id_ex=1, busy=1.
  - stall=1: hold state and all outputs.
  - stall=0 and FLUSH_CYCLES==1: next state IDLE.
  - stall=0 and FLUSH_CYCLES>1: next state FLUSH, cnt<=FLUSH_CYCLES-1.
- FLUSH:
  - pc_redirect=0, flush_if_id=1, flush_id_ex=1.
  - stall=0: cnt decrements; at cnt==1 next state IDLE.
  - stall=1: cnt holds.
- EX inputs are ignored in REDIRECT and FLUSH (wrong-path squash). Counters do not update there.
- Latency: taken in EX at cycle t -> pc_redirect high at t+1 (stall=0). Flush strobes are high for exactly FLUSH_CYCLES non-stalled cycles.
- Back-to-back: a taken branch in EX during the first IDLE cycle after FLUSH is accepted normally.
- Counters (IDLE, !stall, ex_valid & ex_branch only):
  - br_count += 1.
  - br_taken_count += 1 if ex_cond.
  - Both saturate at all-ones, no wrap.
  - Jumps are not counted. Misaligned taken branches are counted.
- All outputs are registered or decoded from state only; no combinational path from ex_* to outputs.

Decomposition:
- Shared defines include file:
  - State encodings: ST_IDLE=2'd0, ST_REDIRECT=2'd1, ST_FLUSH=2'd2.
  - Alignment mask constant.
- Sub-module sat_counter (param W; inc, clk, rst -> q). Instantiated twice for the statistics counters.

Test Plan:
- Taken BEQ: ex_valid=1, ex_branch=1, ex_cond=1, ex_target=0x0000_0040 at t -> pc_redirect=1, redirect_pc=0x40 at t+1; flushes high t+1..t+2; IDLE at t+3; br_count=1, br_taken_count=1.
- Not-taken branch: ex_cond=0 -> no redirect/flush; br_count=1, br_taken_count=0. A jump with ex_target=0x100 -> redirect to 0x100, counters unchanged.
- Misaligned: taken branch with ex_target=0x42 -> misalign_err one-cycle pulse at t+1; pc_redirect stays 0; state IDLE.
- Stall: stall=1 for 3 cycles starting t+1 -> pc_redirect held high 4 cycles total, then 1 FLUSH cycle; total flush window 5 cycles.
- Squash: taken branch to 0x80 presented during REDIRECT/FLUSH -> ignored, redirect_pc remains first target, counters unchanged.
- Reset mid-FLUSH: rst asserted asynchronously -> all outputs 0 without waiting for clk edge. Saturation: with CNT_W=4, 17 taken branches -> both counters=15.
